// File: rtl/regfile_port_ctrl_if.sv
// Bundle of requester handshakes and register-file strobes served by regfile_port_ctrl.
// The controller sits on the slave side; requesters and the register file sit on the master side.
interface regfile_port_ctrl_if #(
    parameter int REG_SZ = 32,
    parameter int IDX_W  = 5
);
    logic              rd0_req;
    logic [IDX_W-1:0]  rd0_idx;
    logic              rd0_gnt;
    logic              rd0_valid;
    logic [REG_SZ-1:0] rd0_data;

    logic              rd1_req;
    logic [IDX_W-1:0]  rd1_idx;
    logic              rd1_gnt;
    logic              rd1_valid;
    logic [REG_SZ-1:0] rd1_data;

    logic              wr_req;
    logic [IDX_W-1:0]  wr_idx;
    logic [REG_SZ-1:0] wr_data;
    logic              wr_ack;

    logic [IDX_W-1:0]  rf_r_idx;
    logic              rf_re;
    logic [IDX_W-1:0]  rf_w_idx;
    logic              rf_we;
    logic [REG_SZ-1:0] rf_din;
    logic [REG_SZ-1:0] rf_dout;

    logic              busy;

    modport slave (
        input  rd0_req, rd0_idx, rd1_req, rd1_idx, wr_req, wr_idx, wr_data, rf_dout,
        output rd0_gnt, rd0_valid, rd0_data, rd1_gnt, rd1_valid, rd1_data, wr_ack,
               rf_r_idx, rf_re, rf_w_idx, rf_we, rf_din, busy
    );

    modport master (
        output rd0_req, rd0_idx, rd1_req, rd1_idx, wr_req, wr_idx, wr_data, rf_dout,
        input  rd0_gnt, rd0_valid, rd0_data, rd1_gnt, rd1_valid, rd1_data, wr_ack,
               rf_r_idx, rf_re, rf_w_idx, rf_we, rf_din, busy
    );
endinterface

// File: rtl/regfile_port_ctrl.sv
// Arbiter/sequencer sharing one register-file read port between two operand fetchers
// and the write port with write-back; turns level handshakes into re/we strobes.
module regfile_port_ctrl #(
    parameter int REG_SZ = 32,
    parameter int IDX_W  = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    regfile_port_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RD_STB, RD_CAP, WR_STB, WR_DONE} state_t;

    state_t            state, state_nx;
    logic              rr_ptr, rr_ptr_nx;
    logic              wr_fair, wr_fair_nx;
    logic              cur_sel, cur_sel_nx;
    logic [IDX_W-1:0]  r_idx_q, r_idx_nx;
    logic [IDX_W-1:0]  w_idx_q, w_idx_nx;
    logic [REG_SZ-1:0] din_q, din_nx;
    logic [REG_SZ-1:0] rd0_q, rd0_nx, rd1_q, rd1_nx;
    logic              rd_any, rd_sel, wr_win;
    logic [IDX_W-1:0]  rd_sel_idx;
    logic [REG_SZ-1:0] cap_data;
    logic              gnt0, gnt1, vld0, vld1, ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rr_ptr  <= 1'b0;
            wr_fair <= 1'b0;
            cur_sel <= 1'b0;
            r_idx_q <= '0;
            w_idx_q <= '0;
            din_q   <= '0;
            rd0_q   <= '0;
            rd1_q   <= '0;
        end else begin
            state   <= state_nx;
            rr_ptr  <= rr_ptr_nx;
            wr_fair <= wr_fair_nx;
            cur_sel <= cur_sel_nx;
            r_idx_q <= r_idx_nx;
            w_idx_q <= w_idx_nx;
            din_q   <= din_nx;
            rd0_q   <= rd0_nx;
            rd1_q   <= rd1_nx;
        end
    end

    // Write wins unless reads are owed a turn; a write to the index about to be read always goes first.
    always_comb begin
        rd_any     = bus.rd0_req | bus.rd1_req;
        rd_sel     = (bus.rd0_req & bus.rd1_req) ? rr_ptr : bus.rd1_req;
        rd_sel_idx = rd_sel ? bus.rd1_idx : bus.rd0_idx;
        wr_win     = bus.wr_req & (~rd_any | ~wr_fair | (bus.wr_idx == rd_sel_idx));
        cap_data   = (r_idx_q == '0) ? '0 : bus.rf_dout;
    end

    always_comb begin
        state_nx   = state;
        rr_ptr_nx  = rr_ptr;
        wr_fair_nx = wr_fair;
        cur_sel_nx = cur_sel;
        r_idx_nx   = r_idx_q;
        w_idx_nx   = w_idx_q;
        din_nx     = din_q;
        rd0_nx     = rd0_q;
        rd1_nx     = rd1_q;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        vld0       = 1'b0;
        vld1       = 1'b0;
        ack        = 1'b0;
        unique case (state)
            IDLE: begin
                if (wr_win) begin
                    state_nx = WR_STB;
                    w_idx_nx = bus.wr_idx;
                    din_nx   = bus.wr_data;
                end else if (rd_any) begin
                    state_nx   = RD_STB;
                    cur_sel_nx = rd_sel;
                    r_idx_nx   = rd_sel_idx;
                    rr_ptr_nx  = ~rd_sel;
                    gnt0       = ~rd_sel;
                    gnt1       = rd_sel;
                end
            end
            RD_STB:  state_nx = RD_CAP;
            RD_CAP: begin
                state_nx   = IDLE;
                wr_fair_nx = 1'b0;
                vld0       = ~cur_sel;
                vld1       = cur_sel;
                if (cur_sel) rd1_nx = cap_data;
                else         rd0_nx = cap_data;
            end
            WR_STB:  state_nx = WR_DONE;
            WR_DONE: begin
                state_nx   = IDLE;
                wr_fair_nx = 1'b1;
                ack        = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Grants are combinational from the requests, so mask them while reset is held.
    assign bus.rd0_gnt   = gnt0 & rst_n;
    assign bus.rd1_gnt   = gnt1 & rst_n;
    assign bus.rd0_valid = vld0;
    assign bus.rd1_valid = vld1;
    assign bus.rd0_data  = vld0 ? cap_data : rd0_q;
    assign bus.rd1_data  = vld1 ? cap_data : rd1_q;
    assign bus.wr_ack    = ack;
    assign bus.rf_r_idx  = r_idx_q;
    assign bus.rf_w_idx  = w_idx_q;
    assign bus.rf_din    = din_q;
    assign bus.rf_re     = (state == RD_STB) && (r_idx_q != '0);
    assign bus.rf_we     = (state == WR_STB) && (w_idx_q != '0);
    assign bus.busy      = (state != IDLE);

    a_rd_held: assert property (@(posedge clk) disable iff (!rst_n)
        (state inside {RD_STB, RD_CAP}) |-> (cur_sel ? bus.rd1_req : bus.rd0_req));
    a_wr_held: assert property (@(posedge clk) disable iff (!rst_n)
        (state inside {WR_STB, WR_DONE}) |-> bus.wr_req);
endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Directed bench for regfile_port_ctrl: a register-file environment, a per-cycle
// transaction-level reference checked on every negedge, and literal scenario checks.
module tb_regfile_port_ctrl;
    localparam int REG_SZ = 32;
    localparam int IDX_W  = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    regfile_port_ctrl_if #(.REG_SZ(REG_SZ), .IDX_W(IDX_W)) bus ();
    regfile_port_ctrl #(.REG_SZ(REG_SZ), .IDX_W(IDX_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    int cyc = 0;
    int rd0_left = 0, rd1_left = 0, wr_left = 0;

    int gnt_log[$];
    int gnt_cyc[$];
    int done_log[$];
    int v_cyc[$];
    logic [REG_SZ-1:0] v_dat[$];
    int re_cyc[$];
    int we_cyc[$];

    function automatic logic [REG_SZ-1:0] init_val(input int i);
        return REG_SZ'(i) << 15;
    endfunction

    function automatic int at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic logic [REG_SZ-1:0] dat_at(input logic [REG_SZ-1:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 'x;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Register file: write and synchronous read on the strobe edge.
    logic [REG_SZ-1:0] rf_mem [32];
    logic [31:0] rf_written = '0;
    always @(posedge clk) begin
        if (bus.rf_we) begin
            rf_mem[bus.rf_w_idx]     <= bus.rf_din;
            rf_written[bus.rf_w_idx] <= 1'b1;
        end
        if (bus.rf_re)
            bus.rf_dout <= rf_written[bus.rf_r_idx] ? rf_mem[bus.rf_r_idx] : init_val(int'(bus.rf_r_idx));
    end

    // Requesters hold their request while they still have transactions outstanding.
    initial begin
        bus.rd0_req = 1'b0; bus.rd0_idx = '0;
        bus.rd1_req = 1'b0; bus.rd1_idx = '0;
        bus.wr_req  = 1'b0; bus.wr_idx  = '0; bus.wr_data = '0;
        forever begin
            @(posedge clk); #1;
            bus.rd0_req = (rd0_left > 0);
            bus.rd1_req = (rd1_left > 0);
            bus.wr_req  = (wr_left > 0);
        end
    end

    // Reference: one operation occupies 3 cycles; op 1=rd0, 2=rd1, 3=write.
    initial begin : model
        logic [REG_SZ-1:0] m_mem [32];
        int op, age, sel, m_ptr, m_fair;
        logic any_rd;
        logic [IDX_W-1:0]  op_idx, sidx, e_r_idx, e_w_idx;
        logic [REG_SZ-1:0] op_data, e_din, e_d0, e_d1;
        for (int i = 0; i < 32; i++) m_mem[i] = init_val(i);
        op = 0; age = 0; m_ptr = 0; m_fair = 0; op_idx = '0; op_data = '0;
        e_r_idx = '0; e_w_idx = '0; e_din = '0; e_d0 = '0; e_d1 = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.rd0_gnt) begin gnt_log.push_back(0); gnt_cyc.push_back(cyc); end
            if (bus.rd1_gnt) begin gnt_log.push_back(1); gnt_cyc.push_back(cyc); end
            if (bus.rd0_valid) begin
                done_log.push_back(0); v_cyc.push_back(cyc); v_dat.push_back(bus.rd0_data);
                if (rd0_left > 0) rd0_left--;
            end
            if (bus.rd1_valid) begin
                done_log.push_back(1); v_cyc.push_back(cyc); v_dat.push_back(bus.rd1_data);
                if (rd1_left > 0) rd1_left--;
            end
            if (bus.wr_ack) begin
                done_log.push_back(2);
                if (wr_left > 0) wr_left--;
            end
            if (bus.rf_re) re_cyc.push_back(cyc);
            if (bus.rf_we) we_cyc.push_back(cyc);

            if (!rst_n) begin
                op = 0; age = 0; m_ptr = 0; m_fair = 0;
                e_r_idx = '0; e_w_idx = '0; e_din = '0; e_d0 = '0; e_d1 = '0;
            end else if (op == 0) begin
                any_rd = bus.rd0_req || bus.rd1_req;
                sel    = (bus.rd0_req && bus.rd1_req) ? m_ptr : (bus.rd1_req ? 1 : 0);
                sidx   = (sel == 1) ? bus.rd1_idx : bus.rd0_idx;
                age    = 0;
                if (bus.wr_req && (!any_rd || m_fair == 0 || bus.wr_idx == sidx)) begin
                    op = 3; op_idx = bus.wr_idx; op_data = bus.wr_data;
                end else if (any_rd) begin
                    op = 1 + sel; op_idx = sidx; m_ptr = 1 - sel;
                end
            end

            if (op != 0 && age == 1) begin
                if (op == 3) begin e_w_idx = op_idx; e_din = op_data; end
                else e_r_idx = op_idx;
            end
            if (op == 1 && age == 2) e_d0 = (op_idx == '0) ? '0 : m_mem[op_idx];
            if (op == 2 && age == 2) e_d1 = (op_idx == '0) ? '0 : m_mem[op_idx];

            chk("rd0_gnt",   64'(bus.rd0_gnt),   64'(op == 1 && age == 0));
            chk("rd1_gnt",   64'(bus.rd1_gnt),   64'(op == 2 && age == 0));
            chk("rd0_valid", 64'(bus.rd0_valid), 64'(op == 1 && age == 2));
            chk("rd1_valid", 64'(bus.rd1_valid), 64'(op == 2 && age == 2));
            chk("wr_ack",    64'(bus.wr_ack),    64'(op == 3 && age == 2));
            chk("rf_re",     64'(bus.rf_re),     64'((op == 1 || op == 2) && age == 1 && op_idx != '0));
            chk("rf_we",     64'(bus.rf_we),     64'(op == 3 && age == 1 && op_idx != '0));
            chk("busy",      64'(bus.busy),      64'(op != 0 && age > 0));
            chk("rd0_data",  64'(bus.rd0_data),  64'(e_d0));
            chk("rd1_data",  64'(bus.rd1_data),  64'(e_d1));
            chk("rf_r_idx",  64'(bus.rf_r_idx),  64'(e_r_idx));
            chk("rf_w_idx",  64'(bus.rf_w_idx),  64'(e_w_idx));
            chk("rf_din",    64'(bus.rf_din),    64'(e_din));

            if (op == 3 && age == 2) begin
                if (op_idx != '0) m_mem[op_idx] = op_data;
                m_fair = 1;
            end
            if ((op == 1 || op == 2) && age == 2) m_fair = 0;
            if (op != 0) begin
                age++;
                if (age == 3) begin op = 0; age = 0; end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic clr();
        gnt_log.delete(); gnt_cyc.delete(); done_log.delete();
        v_cyc.delete(); v_dat.delete(); re_cyc.delete(); we_cyc.delete();
    endtask

    task automatic wait_done(input string name, input int limit);
        int n = 0;
        while ((rd0_left > 0 || rd1_left > 0 || wr_left > 0) && n < limit) begin
            tick();
            n++;
        end
        if (n >= limit) begin
            n_total++;
            $display("FAIL %s timeout: still pending after %0d cycles, required completion", name, limit);
            rd0_left = 0; rd1_left = 0; wr_left = 0;
            tick(); tick(); tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        tick(); tick();
        chk("reset busy",     64'(bus.busy), 64'(0));
        chk("reset rd0_data", 64'(bus.rd0_data), 64'(0));
        rst_n = 1'b1;
        tick();

        // single rd0 read of idx 2
        clr();
        bus.rd0_idx = 5'd2; rd0_left = 1;
        wait_done("t1", 20);
        chk("t1 grant owner", 64'(at(gnt_log, 0)), 64'(0));
        chk("t1 grant count", 64'(gnt_log.size()), 64'(1));
        chk("t1 latency",     64'(at(v_cyc, 0) - at(gnt_cyc, 0)), 64'(2));
        chk("t1 data",        64'(dat_at(v_dat, 0)), 64'(32'h0001_0000));
        chk("t1 re count",    64'(re_cyc.size()), 64'(1));
        chk("t1 re cycle",    64'(at(re_cyc, 0) - at(gnt_cyc, 0)), 64'(1));

        // RAW: write and read of idx 5 raised together
        clr();
        bus.wr_idx = 5'd5; bus.wr_data = 32'hDEAD_BEEF; bus.rd1_idx = 5'd5;
        wr_left = 1; rd1_left = 1;
        wait_done("t2", 30);
        chk("t2 first done", 64'(at(done_log, 0)), 64'(2));
        chk("t2 second done", 64'(at(done_log, 1)), 64'(1));
        chk("t2 data", 64'(dat_at(v_dat, 0)), 64'(32'hDEAD_BEEF));

        // both readers continuously
        clr();
        bus.rd0_idx = 5'd3; bus.rd1_idx = 5'd4;
        rd0_left = 4; rd1_left = 4;
        wait_done("t3", 60);
        for (int i = 0; i < 8; i++) chk($sformatf("t3 grant %0d", i), 64'(at(gnt_log, i)), 64'(i % 2));
        for (int i = 1; i < 8; i++) chk($sformatf("t3 valid gap %0d", i), 64'(at(v_cyc, i) - at(v_cyc, i - 1)), 64'(3));

        // writer and rd0 continuously
        clr();
        bus.wr_idx = 5'd7; bus.wr_data = 32'hCAFE_0007; bus.rd0_idx = 5'd3;
        wr_left = 3; rd0_left = 3;
        wait_done("t4", 60);
        for (int i = 0; i < 6; i++) chk($sformatf("t4 order %0d", i), 64'(at(done_log, i)), 64'((i % 2 == 0) ? 2 : 0));
        for (int i = 1; i < 3; i++) chk($sformatf("t4 read gap %0d", i), 64'((at(v_cyc, i) - at(v_cyc, i - 1)) <= 6), 64'(1));

        // register 0: no strobes, data reads back as zero
        clr();
        bus.wr_idx = 5'd0; bus.wr_data = 32'h0000_1234;
        wr_left = 1;
        wait_done("t5w", 20);
        bus.rd0_idx = 5'd0; rd0_left = 1;
        wait_done("t5r", 20);
        chk("t5 re count", 64'(re_cyc.size()), 64'(0));
        chk("t5 we count", 64'(we_cyc.size()), 64'(0));
        chk("t5 ack first", 64'(at(done_log, 0)), 64'(2));
        chk("t5 read done", 64'(at(done_log, 1)), 64'(0));
        chk("t5 data", 64'(dat_at(v_dat, 0)), 64'(0));

        // reset in the middle of a read strobe
        clr();
        bus.rd0_idx = 5'd2; rd0_left = 1;
        tick();
        chk("t6 grant", 64'(bus.rd0_gnt), 64'(1));
        tick();
        chk("t6 re before reset", 64'(bus.rf_re), 64'(1));
        rst_n = 1'b0; rd0_left = 0;
        #1;
        chk("t6 re in reset", 64'(bus.rf_re), 64'(0));
        chk("t6 busy in reset", 64'(bus.busy), 64'(0));
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        chk("t6 no valid", 64'(v_cyc.size()), 64'(0));
        clr();
        bus.rd1_idx = 5'd2; rd1_left = 1;
        wait_done("t6", 20);
        chk("t6 grant owner", 64'(at(gnt_log, 0)), 64'(1));
        chk("t6 latency", 64'(at(v_cyc, 0) - at(gnt_cyc, 0)), 64'(2));
        chk("t6 data", 64'(dat_at(v_dat, 0)), 64'(32'h0001_0000));
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at 100us, required to finish");
        $fatal(1);
    end
endmodule
